pio_bank: RTL and testbench

Parametrised Avalon-MM parallel-I/O peripheral that generalises the fixed button/LED/hex-display PIO ports of the `pcihellocore` system into one reusable bank. It has configurable input and output widths, per-bit edge capture with selectable polarity, an interrupt mask and set/clear output registers. It sits behind the PCIe hard-IP Avalon-MM master, next to the other PIO slaves in `pcihellocore`. Its input pins connect to board switches and buttons; its output pins drive the LEDs and 7-segment displays.

---
 rtl/pio_bank_pkg.sv | 24 ++
 rtl/pio_debounce.sv | 31 +++
 rtl/pio_bank.sv | 104 ++++++++++
 tb/tb_pio_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_bank_pkg.sv
// Shared definitions for the pio_bank parallel-I/O peripheral: register map
// and edge-select encoding.
package pio_bank_pkg;

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_SET      = 3'd2;
  localparam logic [2:0] ADDR_CLR      = 3'd3;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
  localparam logic [2:0] ADDR_EDGE_SEL = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_sel_e;

  // True when the transition prev -> cur matches the selected polarity.
  function automatic logic edge_hit(edge_sel_e sel, logic cur, logic prev);
    return (sel == EDGE_FALL) ? (prev & ~cur) : (cur & ~prev);
  endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer: q follows d only after d has differed from q for
// DEB_CYCLES consecutive clocks; any return to q restarts the count.
module pio_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= 1'b0;
      cnt <= '0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      q   <= d;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pio_bank.sv
// Avalon-MM parallel-I/O bank with edge capture, interrupt mask and
// set/clear outputs. Define PIO_BANK_DEBOUNCE_EN to add per-bit debouncing.
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int               IN_W       = 16,
  parameter int               OUT_W      = 32,
  parameter logic [OUT_W-1:0] OUT_RESET  = '0,
  parameter int               DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [IN_W-1:0]  in_port,
  output logic [OUT_W-1:0] out_port
);

  logic [IN_W-1:0]  sync1, sync2, filt, prev;
  logic [IN_W-1:0]  irq_mask, edge_cap, edge_sel;
  logic [IN_W-1:0]  edge_now, cap_clr;
  logic [OUT_W-1:0] out_q;
  logic [31:0]      rd_mux;

`ifdef PIO_BANK_DEBOUNCE_EN
  for (genvar i = 0; i < IN_W; i++) begin : g_deb
    pio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .d     (sync2[i]),
      .q     (filt[i])
    );
  end
`else
  assign filt = sync2;
`endif

  // Upper writedata bits are ignored for narrow registers; the count is
  // unused when debouncing is compiled out.
  logic unused_ok;
  assign unused_ok = ^{writedata, DEB_CYCLES};

  always_comb begin
    edge_now = '0;
    for (int i = 0; i < IN_W; i++)
      edge_now[i] = edge_hit(edge_sel_e'(edge_sel[i]), filt[i], prev[i]);
    cap_clr = (write && address == ADDR_EDGE_CAP) ? writedata[IN_W-1:0] : '0;
  end

  // DATA_IN returns the registered filtered value so it moves together
  // with EDGE_CAP. Read mux sees pre-write state, so read+write returns old data.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA_IN:  rd_mux[IN_W-1:0]  = prev;
      ADDR_DATA_OUT: rd_mux[OUT_W-1:0] = out_q;
      ADDR_IRQ_MASK: rd_mux[IN_W-1:0]  = irq_mask;
      ADDR_EDGE_CAP: rd_mux[IN_W-1:0]  = edge_cap;
      ADDR_EDGE_SEL: rd_mux[IN_W-1:0]  = edge_sel;
      default:       rd_mux = '0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      out_q    <= OUT_RESET;
      irq_mask <= '0;
      edge_cap <= '0;
      edge_sel <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      prev     <= filt;
      // A fresh edge overrides a simultaneous write-1-to-clear.
      edge_cap <= (edge_cap & ~cap_clr) | edge_now;
      irq      <= |(edge_cap & irq_mask);
      if (read) readdata <= rd_mux;
      if (write) begin
        case (address)
          ADDR_DATA_OUT: out_q    <= writedata[OUT_W-1:0];
          ADDR_SET:      out_q    <= out_q | writedata[OUT_W-1:0];
          ADDR_CLR:      out_q    <= out_q & ~writedata[OUT_W-1:0];
          ADDR_IRQ_MASK: irq_mask <= writedata[IN_W-1:0];
          ADDR_EDGE_SEL: edge_sel <= writedata[IN_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_pio_bank.sv
// Scoreboard bench for pio_bank: read responses are queued at issue time and
// compared by a monitor when readdata becomes valid.
module tb_pio_bank;

  localparam int IN_W = 16;
  localparam int OUT_W = 32;
  localparam int DEB_CYCLES = 4;
`ifdef PIO_BANK_DEBOUNCE_EN
  localparam int LAT = DEB_CYCLES;
`else
  localparam int LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             read, write;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             irq;
  logic [IN_W-1:0]  in_port;
  logic [OUT_W-1:0] out_port;

  pio_bank #(
    .IN_W(IN_W), .OUT_W(OUT_W), .OUT_RESET(32'hA5), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq),
    .in_port(in_port), .out_port(out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int failures = 0;
  logic rd_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_valid <= read && !reset;

  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: readdata %h with nothing expected", readdata);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        check(e.name, readdata, e.exp);
      end
    end
  end

  // All tasks start and end on a falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
    sb_entry_t e;
    e.name = name; e.exp = exp;
    sb.push_back(e);
    address = a; read = 1'b1;
    tick(1);
    read = 1'b0;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input string name);
    sb_entry_t e;
    e.name = name; e.exp = exp;
    sb.push_back(e);
    address = a; writedata = d; read = 1'b1; write = 1'b1;
    tick(1);
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; in_port = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_out_port", out_port, 32'hA5);
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(3'd0, 32'h0,  "rst_data_in");
    bus_read(3'd1, 32'hA5, "rst_data_out");
    bus_read(3'd2, 32'h0,  "rst_set");
    bus_read(3'd3, 32'h0,  "rst_clr");
    bus_read(3'd4, 32'h0,  "rst_mask");
    bus_read(3'd5, 32'h0,  "rst_edge_cap");
    bus_read(3'd6, 32'h0,  "rst_edge_sel");
    bus_read(3'd7, 32'h0,  "rst_rsvd");

    // Output register, set and clear
    bus_write(3'd1, 32'h0000_0F0F);
    check("wr_data_out", out_port, 32'h0000_0F0F);
    bus_write(3'd2, 32'h0000_F000);
    check("wr_set", out_port, 32'h0000_FF0F);
    bus_write(3'd3, 32'h0000_000F);
    check("wr_clr", out_port, 32'h0000_FF00);
    bus_read(3'd1, 32'h0000_FF00, "rd_data_out");
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, 32'h0, "rsvd_ignored");
    bus_read(3'd2, 32'h0, "set_reads_zero");
    bus_rw(3'd1, 32'h0000_1234, 32'h0000_FF00, "rw_old_value");
    check("rw_write_done", out_port, 32'h0000_1234);

    // Rising edge on bit 0 with interrupt enabled
    bus_write(3'd4, 32'h1);
    bus_write(3'd6, 32'h0);
    in_port[0] = 1'b1;
    tick(2 + LAT);
    check("irq_early", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_before_cap", {31'd0, irq}, 32'd0);
    bus_read(3'd5, 32'h1, "cap_rise0");
    check("irq_assert", {31'd0, irq}, 32'd1);
    bus_read(3'd0, 32'h1, "data_in_bit0");
    bus_write(3'd5, 32'h1);
    check("irq_hold_after_w1c", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_deassert", {31'd0, irq}, 32'd0);
    bus_read(3'd5, 32'h0, "cap_cleared");

    // Falling select on bit 3: rising ignored, falling captured, masked off
    bus_write(3'd6, 32'h8);
    in_port[3] = 1'b1;
    tick(4 + LAT);
    bus_read(3'd5, 32'h0, "cap_rise3_ignored");
    in_port[3] = 1'b0;
    tick(4 + LAT);
    bus_read(3'd5, 32'h8, "cap_fall3");
    check("irq_masked_bit3", {31'd0, irq}, 32'd0);
    bus_write(3'd5, 32'h8);
    bus_read(3'd5, 32'h0, "cap_fall3_cleared");

    // Edge on bit 2 coinciding with its W1C: the capture survives
    bus_write(3'd6, 32'h0);
    in_port[2] = 1'b1;
    tick(4 + LAT);
    in_port[2] = 1'b0;
    tick(4 + LAT);
    bus_read(3'd5, 32'h4, "cap_bit2_before");
    in_port[2] = 1'b1;
    tick(2 + LAT);
    bus_write(3'd5, 32'h4);
    bus_read(3'd5, 32'h4, "cap_set_wins");

    // Reset during a write, input held high through reset
    in_port = 16'h0002;
    reset = 1'b1; address = 3'd1; writedata = 32'h0; write = 1'b1;
    tick(1);
    write = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("reset_beats_write", out_port, 32'hA5);
    bus_read(3'd4, 32'h0, "mask_after_reset");
    tick(8 + LAT);
    bus_read(3'd5, 32'h2, "cap_held_through_reset");
    bus_read(3'd0, 32'h2, "data_in_after_reset");

`ifdef PIO_BANK_DEBOUNCE_EN
    bus_write(3'd5, 32'hFFFF);
    for (int k = 0; k < 8; k++) begin
      in_port[4] = ~in_port[4];
      tick(3);
    end
    tick(8);
    bus_read(3'd0, 32'h2, "deb_toggle_filtered");
    bus_read(3'd5, 32'h0, "deb_toggle_no_cap");
    in_port[4] = 1'b1;
    tick(2 + DEB_CYCLES);
    bus_read(3'd0, 32'h02, "deb_hold_not_yet");
    bus_read(3'd0, 32'h12, "deb_hold_updates");
`endif

    begin : drain
      int budget;
      budget = 20;
      while (sb.size() != 0 && budget > 0) begin
        tick(1);
        budget--;
      end
      if (sb.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL sb_drain: %0d responses outstanding expected 0", sb.size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
